// File: rtl/adc_capture_seq_if.sv
// Capture-sequencer bus: command-decoder config, live ADC samples,
// capture-FIFO write port and status back to the decoder.
interface adc_capture_seq_if #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12,
    parameter int IDX_W  = 3
);
    logic                       RestartReq;
    logic [NUM_CH-1:0]          ChannelSel;
    logic [31:0]                DataNum;
    logic [31:0]                ADC_Speed_Set;
    logic [NUM_CH*DATA_W-1:0]   adc_data;
    logic                       fifo_full;
    logic                       fifo_wr_en;
    logic [IDX_W+DATA_W-1:0]    fifo_wr_data;
    logic                       busy;
    logic                       done;
    logic                       overflow;
    logic                       overrun;
    logic [31:0]                frame_cnt;

    // Decoder / testbench side
    modport master (
        output RestartReq, ChannelSel, DataNum, ADC_Speed_Set, adc_data, fifo_full,
        input  fifo_wr_en, fifo_wr_data, busy, done, overflow, overrun, frame_cnt
    );

    // Sequencer side
    modport slave (
        input  RestartReq, ChannelSel, DataNum, ADC_Speed_Set, adc_data, fifo_full,
        output fifo_wr_en, fifo_wr_data, busy, done, overflow, overrun, frame_cnt
    );
endinterface

// File: rtl/adc_capture_seq.sv
// Multi-channel ADC capture sequencer: sample-rate divider, coherent frame
// snapshot on each tick, back-to-back write of enabled channels into the
// capture FIFO, frame counting up to the configured count.
module adc_capture_seq #(
    parameter int NUM_CH = 8,
    parameter int DATA_W = 12,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    adc_capture_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, WAIT_TICK, SCAN, DONE} state_t;

    state_t                         state, state_nx;
    logic [NUM_CH-1:0]              mask;
    logic [NUM_CH-1:0]              pend;
    logic [NUM_CH-1:0]              pend_rest;
    logic [31:0]                    num;
    logic [31:0]                    period;
    logic [31:0]                    div;
    logic [31:0]                    frame_cnt;
    logic [NUM_CH-1:0][DATA_W-1:0]  snap;
    logic                           overflow;
    logic                           overrun;
    logic                           div_run;
    logic                           tick;
    logic                           last_ch;
    logic                           wr_en;
    logic [IDX_W-1:0]               ch;

    // Divider only runs while a capture is armed; period is never 0 once latched.
    assign div_run   = (state == WAIT_TICK) || (state == SCAN);
    assign tick      = div_run && (div == period - 32'd1);

    // pend with its lowest set bit removed; empty means this is the frame's last channel.
    assign pend_rest = pend & (pend - NUM_CH'(1));
    assign last_ch   = (pend_rest == '0);

    // Lowest pending channel (scan downward so the lowest index wins).
    always_comb begin
        ch = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (pend[i]) ch = IDX_W'(i);
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state and write strobe; a restart overrides whatever the FSM was doing.
    always_comb begin
        state_nx = state;
        wr_en    = 1'b0;
        case (state)
            IDLE:      state_nx = IDLE;
            WAIT_TICK: if (tick) state_nx = SCAN;
            SCAN: begin
                wr_en = 1'b1;
                if (last_ch)
                    state_nx = (frame_cnt + 32'd1 == num) ? DONE : WAIT_TICK;
            end
            DONE:      state_nx = IDLE;
            default:   state_nx = IDLE;
        endcase
        if (bus.RestartReq) begin
            wr_en    = 1'b0;
            state_nx = (bus.DataNum == 32'd0 || bus.ChannelSel == '0) ? DONE : WAIT_TICK;
        end
    end

    // Config latch, divider, snapshot, pending mask, frame count and sticky flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask      <= '0;
            num       <= '0;
            period    <= '0;
            div       <= '0;
            pend      <= '0;
            snap      <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
            overrun   <= 1'b0;
        end else if (bus.RestartReq) begin
            mask      <= bus.ChannelSel;
            num       <= bus.DataNum;
            period    <= (bus.ADC_Speed_Set == 32'd0) ? 32'd1 : bus.ADC_Speed_Set;
            div       <= '0;
            pend      <= '0;
            frame_cnt <= '0;
            overflow  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (!div_run)  div <= '0;
            else if (tick) div <= '0;
            else           div <= div + 32'd1;

            if (state == WAIT_TICK && tick) begin
                snap <= bus.adc_data;
                pend <= mask;
            end

            if (state == SCAN) begin
                pend <= pend_rest;
                if (last_ch)            frame_cnt <= frame_cnt + 32'd1;
                // A tick landing on the last write is simply dropped: the scan is finishing.
                if (tick && !last_ch)   overrun   <= 1'b1;
                if (bus.fifo_full)      overflow  <= 1'b1;
            end
        end
    end

    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_wr_data = {ch, snap[ch]};
    assign bus.busy         = (state != IDLE);
    assign bus.done         = (state == DONE);
    assign bus.overflow     = overflow;
    assign bus.overrun      = overrun;
    assign bus.frame_cnt    = frame_cnt;
endmodule

// File: tb/tb_adc_capture_seq.sv
// Bench for adc_capture_seq: table of configurations plus hand sequences for
// reset mid-scan, FIFO overflow and restart mid-capture. Every FIFO write is
// scored against a queue filled from a tick/scan timing model at restart time.
module tb_adc_capture_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;

    adc_capture_seq_if #(.NUM_CH(8), .DATA_W(12), .IDX_W(3)) bus_if ();

    adc_capture_seq #(.NUM_CH(8), .DATA_W(12), .IDX_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Channel i sample during cycle c is {c[7:0], i[3:0]}.
    always_comb begin
        bus_if.adc_data = '0;
        for (int i = 0; i < 8; i++) bus_if.adc_data[i*12 +: 12] = {cyc[7:0], 4'(i)};
    end

    typedef struct { int cyc; logic [14:0] data; } exp_t;
    typedef struct {
        logic [7:0] mask; int num; int spd;
        int exp_done; int exp_wr; logic exp_ovr; int exp_frames;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[7];
    int   n_checks = 0;
    int   n_pass = 0;
    int   wr_count = 0;
    int   done_count = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Timing model: ticks at r+P*j; a frame started by tick t writes at t+1..t+K,
    // then the next frame starts at the first tick at or after t+K+1.
    task automatic push_expected(input logic [7:0] m, input int n, input int s, input int r);
        int p, t, k;
        exp_t e;
        p = (s == 0) ? 1 : s;
        if (m == 8'h00 || n == 0) return;
        t = r + p;
        for (int f = 0; f < n; f++) begin
            k = 0;
            for (int c = 0; c < 8; c++) begin
                if (m[c]) begin
                    k++;
                    e.cyc  = t + k;
                    e.data = {3'(c), 8'(t), 4'(c)};
                    exp_q.push_back(e);
                end
            end
            t = r + p * ((t + k + 1 - r + p - 1) / p);
        end
    endtask

    // Called at #1 after a posedge; returns at #1 of the cycle after the restart.
    task automatic do_restart(input logic [7:0] m, input int n, input int s, output int r);
        bus_if.ChannelSel    = m;
        bus_if.DataNum       = 32'(n);
        bus_if.ADC_Speed_Set = 32'(s);
        bus_if.RestartReq    = 1'b1;
        r = cyc;
        while (exp_q.size() > 0 && exp_q[$].cyc >= r) void'(exp_q.pop_back());
        push_expected(m, n, s, r);
        @(negedge clk);
        chk("no_write_in_restart_cycle", 64'(bus_if.fifo_wr_en), 64'd0);
        @(posedge clk); #1;
        bus_if.RestartReq = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(output int dc);
        dc = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus_if.done) begin dc = cyc; break; end
        end
        n_checks++;
        if (dc >= 0) n_pass++;
        else $display("FAIL done_timeout: no done pulse within 400 cycles (cycle %0d)", cyc);
    endtask

    // Scoreboard: every write must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus_if.fifo_wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got data %0h at cycle %0d, required none", bus_if.fifo_wr_data, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_cycle", 64'(cyc), 64'(mon_e.cyc));
                chk("wr_data", 64'(bus_if.fifo_wr_data), 64'(mon_e.data));
            end
        end
        if (bus_if.done) done_count++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, r2, dc;
        //         mask   num spd  done  wr  ovr frames
        vecs[0] = '{8'h05, 3, 10,  33,   6, 1'b0, 3};
        vecs[1] = '{8'h00, 3, 10,   1,   0, 1'b0, 0};
        vecs[2] = '{8'h0F, 0,  5,   1,   0, 1'b0, 0};
        vecs[3] = '{8'h01, 4,  0,   9,   4, 1'b0, 4};
        vecs[4] = '{8'hFF, 2,  4,  25,  16, 1'b1, 2};
        vecs[5] = '{8'hA6, 2,  3,  14,   8, 1'b1, 2};
        vecs[6] = '{8'h81, 2,  2,   9,   4, 1'b0, 2};

        bus_if.RestartReq = 1'b0; bus_if.ChannelSel = '0; bus_if.DataNum = '0;
        bus_if.ADC_Speed_Set = '0; bus_if.fifo_full = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 64'({bus_if.busy, bus_if.done, bus_if.fifo_wr_en, bus_if.overflow,
                                  bus_if.overrun, bus_if.frame_cnt}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset during SCAN
        @(posedge clk); #1;
        do_restart(8'hFF, 5, 4, r);
        wait_until(r + 7);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("reset_mid_scan_outputs", 64'({bus_if.busy, bus_if.done, bus_if.fifo_wr_en, bus_if.overflow,
                                           bus_if.overrun, bus_if.frame_cnt}), 64'd0);
        repeat (8) @(negedge clk);
        chk("idle_after_reset", 64'(bus_if.busy), 64'd0);

        // Configuration table
        foreach (vecs[v]) begin
            @(posedge clk); #1;
            do_restart(vecs[v].mask, vecs[v].num, vecs[v].spd, r);
            wr_count = 0; done_count = 0;
            wait_done(dc);
            chk($sformatf("v%0d_done_cycle", v), 64'(dc - r), 64'(vecs[v].exp_done));
            chk($sformatf("v%0d_writes", v), 64'(wr_count), 64'(vecs[v].exp_wr));
            chk($sformatf("v%0d_overrun", v), 64'(bus_if.overrun), 64'(vecs[v].exp_ovr));
            chk($sformatf("v%0d_overflow", v), 64'(bus_if.overflow), 64'd0);
            chk($sformatf("v%0d_frame_cnt", v), 64'(bus_if.frame_cnt), 64'(vecs[v].exp_frames));
            @(negedge clk);
            chk($sformatf("v%0d_busy_after_done", v), 64'(bus_if.busy), 64'd0);
            chk($sformatf("v%0d_done_pulses", v), 64'(done_count), 64'd1);
            chk($sformatf("v%0d_queue_drained", v), 64'(exp_q.size()), 64'd0);
        end

        // Overflow: FIFO full on the second write of a 4-channel frame
        @(posedge clk); #1;
        do_restart(8'h0F, 1, 3, r);
        wr_count = 0; done_count = 0;
        wait_until(r + 5);
        bus_if.fifo_full = 1'b1;
        @(posedge clk); #1;
        bus_if.fifo_full = 1'b0;
        @(negedge clk);
        chk("overflow_set", 64'(bus_if.overflow), 64'd1);
        wait_done(dc);
        chk("ovf_done_cycle", 64'(dc - r), 64'd8);
        @(negedge clk);
        chk("overflow_sticky", 64'(bus_if.overflow), 64'd1);
        chk("ovf_writes", 64'(wr_count), 64'd4);

        // Restart mid-capture (also clears the sticky overflow)
        @(posedge clk); #1;
        do_restart(8'h0F, 3, 6, r);
        @(negedge clk);
        chk("overflow_cleared", 64'(bus_if.overflow), 64'd0);
        wait_until(r + 14);
        chk("frame_cnt_before_abort", 64'(bus_if.frame_cnt), 64'd1);
        do_restart(8'h80, 2, 3, r2);
        wr_count = 0; done_count = 0;
        @(negedge clk);
        chk("frame_cnt_after_restart", 64'(bus_if.frame_cnt), 64'd0);
        wait_done(dc);
        chk("restart_done_cycle", 64'(dc - r2), 64'd8);
        chk("restart_writes", 64'(wr_count), 64'd2);
        repeat (20) @(negedge clk);
        chk("restart_done_pulses", 64'(done_count), 64'd1);
        chk("restart_queue_drained", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
